// File: rtl/mem_stage_if.sv
// Pipeline-side and data-memory-side signals of the memory-access stage.
// The stage owns the master modport. The execute stage and the memory use the slave view.
interface mem_stage_if;
    logic        valid_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_result_i;
    logic [31:0] rs2_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] load_data_o;
    logic [1:0]  err_o;
    logic        req_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        gnt_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;

    modport master (
        input  valid_i, mem_read_i, mem_write_i, funct3_i, alu_result_i, rs2_i,
        output stall_o, done_o, load_data_o, err_o,
        output req_o, we_o, addr_o, wdata_o, be_o,
        input  gnt_i, rvalid_i, rdata_i
    );

    modport slave (
        output valid_i, mem_read_i, mem_write_i, funct3_i, alu_result_i, rs2_i,
        input  stall_o, done_o, load_data_o, err_o,
        input  req_o, we_o, addr_o, wdata_o, be_o,
        output gnt_i, rvalid_i, rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues loads and stores on a req/gnt/rvalid bus,
// stalls the pipeline while an access is in flight, and reports the result with a done pulse.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_n_i,
    mem_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          load_reg;
    logic [2:0]    f3_reg;
    logic [1:0]    off_reg;
    logic          req_reg;
    logic          we_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    be_reg;
    logic          done_reg;
    logic [31:0]   load_data_reg;
    logic [1:0]    err_reg;

    logic          access;
    logic [2:0]    f3;
    logic [1:0]    off;
    logic          illegal;
    logic          misaligned;
    logic [1:0]    acc_err;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [7:0]    rbyte [4];
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_value;
    logic          timeout_hit;

    assign access = bus.valid_i && (bus.mem_read_i || bus.mem_write_i);
    assign f3     = bus.funct3_i;
    assign off    = bus.alu_result_i[1:0];

    // Decode of the incoming access; illegal encodings win over misalignment.
    always_comb begin
        illegal    = (bus.mem_read_i && bus.mem_write_i) || (f3 == 3'b011) ||
                     (f3[2:1] == 2'b11) || (bus.mem_write_i && f3[2]);
        misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                     ((f3[1:0] == 2'b10) && (off != 2'b00));
        acc_err    = illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
        case (f3[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << off;
                lane_wdata = {4{bus.rs2_i[7:0]}};
            end
            2'b01: begin
                lane_be    = off[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{bus.rs2_i[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = bus.rs2_i;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rbyte[gi] = bus.rdata_i[8*gi +: 8];
    end

    always_comb begin
        sel_byte = rbyte[off_reg];
        sel_half = off_reg[1] ? bus.rdata_i[31:16] : bus.rdata_i[15:0];
        case (f3_reg)
            3'b000:  load_value = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_value = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_value = bus.rdata_i;
            3'b100:  load_value = {24'b0, sel_byte};
            3'b101:  load_value = {16'b0, sel_half};
            default: load_value = 32'b0;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == TO_LAST);

    assign bus.stall_o     = (state_reg == REQ) || (state_reg == WAIT) ||
                             ((state_reg == IDLE) && access);
    assign bus.done_o      = done_reg;
    assign bus.load_data_o = load_data_reg;
    assign bus.err_o       = err_reg;
    assign bus.req_o       = req_reg;
    assign bus.we_o        = we_reg;
    assign bus.addr_o      = addr_reg;
    assign bus.wdata_o     = wdata_reg;
    assign bus.be_o        = be_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            load_reg      <= 1'b0;
            f3_reg        <= 3'b0;
            off_reg       <= 2'b0;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= 32'b0;
            wdata_reg     <= 32'b0;
            be_reg        <= 4'b0;
            done_reg      <= 1'b0;
            load_data_reg <= 32'b0;
            err_reg       <= 2'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (access) begin
                        f3_reg   <= f3;
                        off_reg  <= off;
                        load_reg <= bus.mem_read_i;
                        if (acc_err != 2'b00) begin
                            err_reg       <= acc_err;
                            load_data_reg <= 32'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            req_reg   <= 1'b1;
                            we_reg    <= bus.mem_write_i;
                            addr_reg  <= {bus.alu_result_i[31:2], 2'b00};
                            wdata_reg <= lane_wdata;
                            be_reg    <= lane_be;
                            state_reg <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (timeout_hit) begin
                        req_reg   <= 1'b0;
                        err_reg   <= 2'b10;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else if (bus.gnt_i) begin
                        req_reg <= 1'b0;
                        if (!load_reg || bus.rvalid_i) begin
                            load_data_reg <= load_reg ? load_value : 32'b0;
                            err_reg       <= 2'b00;
                            done_reg      <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (timeout_hit) begin
                        err_reg   <= 2'b10;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else if (bus.rvalid_i) begin
                        load_data_reg <= load_value;
                        err_reg       <= 2'b00;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                default: begin
                    cnt_reg       <= '0;
                    done_reg      <= 1'b0;
                    err_reg       <= 2'b00;
                    load_data_reg <= 32'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance with the default timeout for
// functional accesses, and one with a 4-cycle timeout for the abort path.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_stage_if bus_a ();
    mem_stage_if bus_b ();

    mem_stage #(.TIMEOUT_CYCLES(256)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_a)
    );

    mem_stage #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.valid_i = 0; bus_a.mem_read_i = 0; bus_a.mem_write_i = 0; bus_a.funct3_i = 0;
        bus_a.alu_result_i = 0; bus_a.rs2_i = 0; bus_a.gnt_i = 0; bus_a.rvalid_i = 0; bus_a.rdata_i = 0;
        bus_b.valid_i = 0; bus_b.mem_read_i = 0; bus_b.mem_write_i = 0; bus_b.funct3_i = 0;
        bus_b.alu_result_i = 0; bus_b.rs2_i = 0; bus_b.gnt_i = 0; bus_b.rvalid_i = 0; bus_b.rdata_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus_a.req_o, bus_a.we_o, bus_a.done_o, bus_a.stall_o, bus_a.err_o, bus_a.be_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0",
                     {bus_a.req_o, bus_a.we_o, bus_a.done_o, bus_a.stall_o, bus_a.err_o, bus_a.be_o});
        end
        checks++;
        if ({bus_a.addr_o, bus_a.wdata_o, bus_a.load_data_o} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {bus_a.addr_o, bus_a.wdata_o, bus_a.load_data_o});
        end
        checks++;
        if ({bus_b.req_o, bus_b.done_o, bus_b.stall_o} !== 3'b0) begin
            errors++;
            $display("FAIL reset_to_inst: got %b expected 000", {bus_b.req_o, bus_b.done_o, bus_b.stall_o});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("reset: checked output state");
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rs2, input int gd, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata);
        bus_a.valid_i = 1; bus_a.mem_read_i = 0; bus_a.mem_write_i = 1;
        bus_a.funct3_i = f3; bus_a.alu_result_i = addr; bus_a.rs2_i = rs2;
        @(negedge clk);
        checks++;
        if ({bus_a.stall_o, bus_a.req_o} !== 2'b10) begin
            errors++;
            $display("FAIL %s_accept: stall,req got %b expected 10", name, {bus_a.stall_o, bus_a.req_o});
        end
        tick();
        bus_a.valid_i = 0; bus_a.mem_write_i = 0;
        for (int c = 0; c <= gd; c++) begin
            bus_a.gnt_i = (c == gd);
            @(negedge clk);
            checks++;
            if ({bus_a.req_o, bus_a.we_o, bus_a.stall_o, bus_a.done_o} !== 4'b1110) begin
                errors++;
                $display("FAIL %s_req: req,we,stall,done got %b expected 1110 (cycle %0d)", name,
                         {bus_a.req_o, bus_a.we_o, bus_a.stall_o, bus_a.done_o}, c);
            end
            checks++;
            if ({bus_a.addr_o, bus_a.be_o, bus_a.wdata_o} !== {addr & 32'hFFFF_FFFC, exp_be, exp_wdata}) begin
                errors++;
                $display("FAIL %s_bus: addr/be/wdata got %h/%b/%h expected %h/%b/%h", name,
                         bus_a.addr_o, bus_a.be_o, bus_a.wdata_o, addr & 32'hFFFF_FFFC, exp_be, exp_wdata);
            end
            tick();
        end
        bus_a.gnt_i = 0;
        @(negedge clk);
        checks++;
        if ({bus_a.done_o, bus_a.stall_o, bus_a.req_o, bus_a.err_o, bus_a.load_data_o} !== {5'b10000, 32'b0}) begin
            errors++;
            $display("FAIL %s_done: done,stall,req,err got %b load_data %h expected 10000/0", name,
                     {bus_a.done_o, bus_a.stall_o, bus_a.req_o, bus_a.err_o}, bus_a.load_data_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus_a.done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: done got %b expected 0", name, bus_a.done_o);
        end
        tick();
        $display("store %s addr=%h rs2=%h be=%b wdata=%h", name, addr, rs2, exp_be, exp_wdata);
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input int gd, input int rd,
                             input logic [3:0] exp_be, input logic [31:0] exp_data);
        bus_a.valid_i = 1; bus_a.mem_read_i = 1; bus_a.mem_write_i = 0;
        bus_a.funct3_i = f3; bus_a.alu_result_i = addr; bus_a.rs2_i = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if ({bus_a.stall_o, bus_a.req_o} !== 2'b10) begin
            errors++;
            $display("FAIL %s_accept: stall,req got %b expected 10", name, {bus_a.stall_o, bus_a.req_o});
        end
        tick();
        bus_a.valid_i = 0; bus_a.mem_read_i = 0;
        for (int c = 0; c <= gd + rd; c++) begin
            bus_a.gnt_i    = (c == gd);
            bus_a.rvalid_i = (c == gd + rd);
            bus_a.rdata_i  = (c == gd + rd) ? rdata : 32'h5A5A_5A5A;
            @(negedge clk);
            checks++;
            if ({bus_a.req_o, bus_a.stall_o, bus_a.done_o} !== {(c <= gd), 2'b10}) begin
                errors++;
                $display("FAIL %s_phase: req,stall,done got %b expected %b (cycle %0d)", name,
                         {bus_a.req_o, bus_a.stall_o, bus_a.done_o}, {(c <= gd), 2'b10}, c);
            end
            if (c == 0) begin
                checks++;
                if ({bus_a.we_o, bus_a.addr_o, bus_a.be_o} !== {1'b0, addr & 32'hFFFF_FFFC, exp_be}) begin
                    errors++;
                    $display("FAIL %s_bus: we/addr/be got %b/%h/%b expected 0/%h/%b", name,
                             bus_a.we_o, bus_a.addr_o, bus_a.be_o, addr & 32'hFFFF_FFFC, exp_be);
                end
            end
            tick();
        end
        bus_a.gnt_i = 0; bus_a.rvalid_i = 0; bus_a.rdata_i = 0;
        @(negedge clk);
        checks++;
        if ({bus_a.done_o, bus_a.stall_o, bus_a.err_o} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_done: done,stall,err got %b expected 1000", name,
                     {bus_a.done_o, bus_a.stall_o, bus_a.err_o});
        end
        checks++;
        if (bus_a.load_data_o !== exp_data) begin
            errors++;
            $display("FAIL %s_data: load_data got %h expected %h", name, bus_a.load_data_o, exp_data);
        end
        tick();
        $display("load %s addr=%h rdata=%h gnt_delay=%0d rvalid_delay=%0d data=%h",
                 name, addr, rdata, gd, rd, exp_data);
    endtask

    task automatic test_access_error(input string name, input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] addr, input logic [1:0] exp_err);
        bus_a.valid_i = 1; bus_a.mem_read_i = rd; bus_a.mem_write_i = wr;
        bus_a.funct3_i = f3; bus_a.alu_result_i = addr; bus_a.rs2_i = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({bus_a.stall_o, bus_a.req_o} !== 2'b10) begin
            errors++;
            $display("FAIL %s_accept: stall,req got %b expected 10", name, {bus_a.stall_o, bus_a.req_o});
        end
        tick();
        bus_a.valid_i = 0; bus_a.mem_read_i = 0; bus_a.mem_write_i = 0;
        @(negedge clk);
        checks++;
        if ({bus_a.done_o, bus_a.req_o, bus_a.stall_o, bus_a.err_o, bus_a.load_data_o} !== {3'b100, exp_err, 32'b0}) begin
            errors++;
            $display("FAIL %s_err: done,req,stall got %b err %b data %h expected 100 err %b data 0", name,
                     {bus_a.done_o, bus_a.req_o, bus_a.stall_o}, bus_a.err_o, bus_a.load_data_o, exp_err);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus_a.done_o, bus_a.req_o} !== 2'b00) begin
            errors++;
            $display("FAIL %s_after: done,req got %b expected 00", name, {bus_a.done_o, bus_a.req_o});
        end
        tick();
        $display("error %s addr=%h funct3=%b err=%b", name, addr, f3, exp_err);
    endtask

    task automatic test_non_memory();
        bus_a.valid_i = 1; bus_a.mem_read_i = 0; bus_a.mem_write_i = 0;
        bus_a.funct3_i = 3'b010; bus_a.alu_result_i = 32'h0000_0102;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({bus_a.stall_o, bus_a.done_o, bus_a.req_o} !== 3'b000) begin
                errors++;
                $display("FAIL nonmem: stall,done,req got %b expected 000 (cycle %0d)",
                         {bus_a.stall_o, bus_a.done_o, bus_a.req_o}, c);
            end
            tick();
        end
        bus_a.valid_i = 0;
        $display("non-memory: 3 cycles without stall");
    endtask

    task automatic test_timeout();
        bus_b.valid_i = 1; bus_b.mem_read_i = 1; bus_b.mem_write_i = 0;
        bus_b.funct3_i = 3'b010; bus_b.alu_result_i = 32'h0000_0040; bus_b.gnt_i = 0;
        @(negedge clk);
        tick();
        bus_b.valid_i = 0; bus_b.mem_read_i = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({bus_b.req_o, bus_b.stall_o, bus_b.done_o} !== 3'b110) begin
                errors++;
                $display("FAIL timeout_req: req,stall,done got %b expected 110 (cycle %0d)",
                         {bus_b.req_o, bus_b.stall_o, bus_b.done_o}, c);
            end
            tick();
        end
        bus_b.gnt_i = 1; bus_b.rvalid_i = 1; bus_b.rdata_i = 32'hDEAD_0000;
        @(negedge clk);
        checks++;
        if ({bus_b.done_o, bus_b.req_o, bus_b.stall_o, bus_b.err_o, bus_b.load_data_o} !== {5'b10010, 32'b0}) begin
            errors++;
            $display("FAIL timeout_done: done,req,stall,err got %b data %h expected 10010 data 0",
                     {bus_b.done_o, bus_b.req_o, bus_b.stall_o, bus_b.err_o}, bus_b.load_data_o);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus_b.done_o, bus_b.req_o, bus_b.stall_o} !== 3'b000) begin
                errors++;
                $display("FAIL timeout_late_gnt: done,req,stall got %b expected 000 (cycle %0d)",
                         {bus_b.done_o, bus_b.req_o, bus_b.stall_o}, c);
            end
            tick();
        end
        bus_b.gnt_i = 0; bus_b.rvalid_i = 0; bus_b.rdata_i = 0;
        $display("timeout: 4 request cycles then err=10, late gnt ignored");
    endtask

    task automatic test_reset_mid_access();
        // Reset while the request is outstanding.
        bus_a.valid_i = 1; bus_a.mem_read_i = 1; bus_a.funct3_i = 3'b010; bus_a.alu_result_i = 32'h80;
        tick();
        bus_a.valid_i = 0; bus_a.mem_read_i = 0;
        #1;
        checks++;
        if (bus_a.req_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_req_pre: req got %b expected 1", bus_a.req_o);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.req_o, bus_a.stall_o, bus_a.done_o} !== 3'b000) begin
            errors++;
            $display("FAIL rst_in_req: req,stall,done got %b expected 000",
                     {bus_a.req_o, bus_a.stall_o, bus_a.done_o});
        end
        tick();
        rst_n = 1'b1;
        // Reset while waiting for read data.
        bus_a.valid_i = 1; bus_a.mem_read_i = 1; bus_a.funct3_i = 3'b010; bus_a.alu_result_i = 32'h84;
        tick();
        bus_a.valid_i = 0; bus_a.mem_read_i = 0; bus_a.gnt_i = 1;
        tick();
        bus_a.gnt_i = 0;
        #1;
        checks++;
        if ({bus_a.req_o, bus_a.stall_o} !== 2'b01) begin
            errors++;
            $display("FAIL rst_wait_pre: req,stall got %b expected 01", {bus_a.req_o, bus_a.stall_o});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.req_o, bus_a.stall_o, bus_a.done_o} !== 3'b000) begin
            errors++;
            $display("FAIL rst_in_wait: req,stall,done got %b expected 000",
                     {bus_a.req_o, bus_a.stall_o, bus_a.done_o});
        end
        tick();
        rst_n = 1'b1;
        bus_a.rvalid_i = 1; bus_a.rdata_i = 32'h0BAD_0BAD;
        @(negedge clk);
        tick();
        bus_a.rvalid_i = 0; bus_a.rdata_i = 0;
        @(negedge clk);
        checks++;
        if ({bus_a.done_o, bus_a.stall_o, bus_a.req_o} !== 3'b000) begin
            errors++;
            $display("FAIL rst_discard: done,stall,req got %b expected 000",
                     {bus_a.done_o, bus_a.stall_o, bus_a.req_o});
        end
        tick();
        $display("reset mid-access: REQ and WAIT aborted");
        test_load("lw_after_rst", 3'b010, 32'h88, 32'h1357_9BDF, 0, 1, 4'b1111, 32'h1357_9BDF);
    endtask

    task automatic test_back_to_back();
        test_store("sw_b2b", 3'b010, 32'h0000_0010, 32'h0102_0304, 0, 4'b1111, 32'h0102_0304);
        test_load("lw_b2b", 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 0, 1, 4'b1111, 32'hCAFE_F00D);
        test_load("lhu_same_cycle", 3'b101, 32'h0000_0100, 32'h1234_ABCD, 0, 0, 4'b0011, 32'h0000_ABCD);
        test_load("lb_lane1", 3'b000, 32'h0000_0101, 32'h1234_ABCD, 1, 0, 4'b0010, 32'hFFFF_FFAB);
    endtask

    initial begin
        test_reset();
        test_store("sw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF);
        test_load("lb", 3'b000, 32'h0000_0203, 32'h8012_3456, 3, 2, 4'b1000, 32'hFFFF_FF80);
        test_load("lbu", 3'b100, 32'h0000_0203, 32'h8012_3456, 3, 2, 4'b1000, 32'h0000_0080);
        test_load("lh", 3'b001, 32'h0000_0202, 32'h8012_3456, 3, 2, 4'b1100, 32'hFFFF_8012);
        test_store("sb", 3'b000, 32'h0000_0005, 32'h0000_00AB, 1, 4'b0010, 32'hABAB_ABAB);
        test_store("sh", 3'b001, 32'h0000_0006, 32'h0000_1234, 0, 4'b1100, 32'h1234_1234);
        test_access_error("lw_misaligned", 1'b1, 1'b0, 3'b010, 32'h0000_0102, 2'b01);
        test_access_error("load_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 2'b11);
        test_access_error("store_f3_100", 1'b0, 1'b1, 3'b100, 32'h0000_0100, 2'b11);
        test_access_error("rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h0000_0100, 2'b11);
        test_access_error("illegal_over_misalign", 1'b0, 1'b1, 3'b101, 32'h0000_0001, 2'b11);
        test_access_error("sh_misaligned", 1'b0, 1'b1, 3'b001, 32'h0000_0007, 2'b01);
        test_non_memory();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
